if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction SRAM port.
- Applies branch/jump redirects returned from ID on br_bus.
- Produces if_to_id_bus {ce, pc}, plus an instruction word that stays stable across ID stalls. A hold buffer captures the SRAM word when ID freezes, so no instruction is lost.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetched instruction.
- STALL_W, 6, width of the stall bus (`StallBus).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_W  per-stage stop vector. bit0 = PC/IF, bit1 = ID, bit2 = EX. `Stop = 1, `NoStop = 0.
- br_bus  in  33  {br_e[32], br_addr[31:0]} from ID, combinational.
- if_to_id_bus  out  33  {ce[32], pc[31:0]} (`IF_TO_ID_WD).
- inst_sram_en  out  1  instruction SRAM enable.
- inst_sram_wen  out  4  SRAM byte write enables; constant 4'b0000.
- inst_sram_addr  out  32  SRAM address.
- inst_sram_wdata  out  32  constant 32'b0.
- inst_sram_rdata  in  32  synchronous SRAM read data; valid one cycle after the address is presented.
- inst_out  out  32  instruction word for ID.

Behaviour:
- State:
  - pc_reg[31:0], reset RESET_PC-4 (32'hBFBF_FFFC).
  - ce_reg, reset 0.
  - inst_hold[31:0], reset 0.
  - hold_valid, reset 0.
  - All four clear asynchronously on rst rising; no clock needed.
- next_pc = br_e ? br_addr : pc_reg + 4. Arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Update rule (posedge, rst low):
  - stall[0] == `NoStop: pc_reg <= next_pc; ce_reg <= 1.
  - stall[0] == `Stop: pc_reg and ce_reg hold. br_e in that cycle is ignored, because ID re-presents the branch after the stall.
- Outputs:
  - inst_sram_en = ce_reg.
  - inst_sram_addr = pc_reg.
  - if_to_id_bus = {ce_reg, pc_reg}.
  - During reset and the first cycle after it: en = 0, bus = {0, 32'hBFBF_FFFC}.
- Fetch timeline:
  - First edge after reset release (no stall): pc_reg = 32'hBFC0_0000, en = 1.
  - ID latches the bus on the next edge; rdata for that pc arrives in the same cycle ID holds it.
  - Branch latency: redirect applies on the edge ending the cycle in which ID presents br_e = 1.
  - At that point pc_reg already holds the delay-slot address, so the delay slot is fetched and executed; the target follows it. No flush.
- Hold buffer:
  - Capture: on an edge with stall[1] == `Stop and hold_valid == 0, inst_hold <= inst_sram_rdata and hold_valid <= 1.
  - While hold_valid == 1 and stall[1] stays `Stop: no recapture.
  - Release: on an edge with stall[1] == `NoStop, hold_valid <= 0.
  - inst_out = hold_valid ? inst_hold : inst_sram_rdata.
  - Result: during a stall of any length, including the release cycle, inst_out equals the word ID held when the stall began.
- Simultaneous events:
  - stall[1] released and stall[0] asserted on the same edge is legal. hold clears, PC holds.
  - ID bubble case (stall[1] = Stop, stall[2] = NoStop): ID inserts a bubble, but the hold buffer still captures, because ID re-executes the held instruction next.
- Reset mid-stall or mid-branch: all state returns to reset values immediately. The pending redirect is discarded.
- No exception detection. Misaligned br_addr is passed through unchanged.

Test Plan:
1. Reset release, no stall, sequential fetch:
   - Edge 1: pc = BFC0_0000, en = 1.
   - Following edges: pc = BFC0_0004, then BFC0_0008.
   - ce = 1 from edge 1 onward.
2. Branch redirect: br_bus = {1, 32'hBFC0_0100} for one cycle while pc = BFC0_0008.
   - Next pc = BFC0_0100.
   - The delay slot BFC0_0008 is still emitted on the bus before the target.
3. Stall hold: stall = 6'b000011 for 3 cycles while rdata = 32'h2408_0001, then rdata changes to 32'h2409_0002.
   - inst_out stays 2408_0001 through the release cycle.
   - pc frozen throughout.
   - inst_out shows 2409_0002 the cycle after release.
4. Branch during stall: br_e = 1 with stall[0] = 1.
   - pc unchanged.
   - After the stall, br_e = 1 again → redirect is taken.
5. Async reset mid-stall: rst pulses between edges while hold_valid = 1.
   - Immediately: pc = BFBF_FFFC, en = 0, hold_valid = 0, inst_out = rdata.
6. Wrap: force pc_reg = FFFF_FFFC, no branch.
   - Next pc = 0000_0000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM port and
// keeps the fetched word stable for ID across stalls via a one-entry hold buffer.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [32:0]        br_bus,
    output logic [32:0]        if_to_id_bus,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata,
    input  logic [31:0]        inst_sram_rdata,
    output logic [31:0]        inst_out
);

    localparam logic STOP = 1'b1;

    logic [31:0] pc_reg;
    logic        ce_reg;
    logic [31:0] inst_hold;
    logic        hold_valid;
    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;
    logic        stall_unused;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign next_pc = br_e ? br_addr : pc_reg + 32'd4;

    // Only the IF and ID stop bits matter here; later stages are ignored.
    assign stall_unused = ^stall[STALL_W-1:2];

    // A branch presented while IF is stopped is dropped; ID re-presents it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_PC - 32'd4;
            ce_reg <= 1'b0;
        end else if (stall[0] != STOP) begin
            pc_reg <= next_pc;
            ce_reg <= 1'b1;
        end
    end

    // Capture the SRAM word on the first stalled edge so ID keeps seeing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_hold  <= 32'd0;
            hold_valid <= 1'b0;
        end else if (stall[1] == STOP) begin
            if (!hold_valid) begin
                inst_hold  <= inst_sram_rdata;
                hold_valid <= 1'b1;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    assign inst_sram_en    = ce_reg;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'd0;
    assign if_to_id_bus    = {ce_reg, pc_reg};
    assign inst_out        = hold_valid ? inst_hold : inst_sram_rdata;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, reset/stall corner
// sequences, then randomized stimulus against a behavioural model.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] inst_out;

    int checks;
    int failures;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_out        (inst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  st;
        logic        be;
        logic [31:0] ba;
        logic [31:0] rd;
        logic [31:0] pc;
        logic        ce;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic [5:0] st, input logic be, input logic [31:0] ba,
                                input logic [31:0] rd, input logic [31:0] pc, input logic ce,
                                input logic [31:0] inst);
        vec_t v;
        v.st = st; v.be = be; v.ba = ba; v.rd = rd; v.pc = pc; v.ce = ce; v.inst = inst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present inputs, take one edge, then the SRAM word for the new PC appears.
    task automatic drive(input logic [5:0] st, input logic be, input logic [31:0] ba,
                         input logic [31:0] rd_next);
        stall  = st;
        br_bus = {be, ba};
        @(posedge clk);
        #1 inst_sram_rdata = rd_next;
        @(negedge clk);
    endtask

    task automatic chk_outputs(input string tag, input logic [31:0] pc, input logic ce,
                               input logic [31:0] inst);
        chk({tag, " pc"}, if_to_id_bus[31:0], pc);
        chk({tag, " ce"}, {31'd0, if_to_id_bus[32]}, {31'd0, ce});
        chk({tag, " en"}, {31'd0, inst_sram_en}, {31'd0, ce});
        chk({tag, " addr"}, inst_sram_addr, pc);
        chk({tag, " inst"}, inst_out, inst);
    endtask

    // Behavioural model state: fetch address, enable, and the word ID is frozen on.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_frozen;
    logic [31:0] m_word;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        stall    = 6'd0;
        br_bus   = 33'd0;
        inst_sram_rdata = 32'hDEAD_0000;

        tbl[0]  = mk(6'b000000, 1'b0, 32'h0,         32'h1000_0000, 32'hBFC0_0000, 1'b1, 32'h1000_0000);
        tbl[1]  = mk(6'b000000, 1'b0, 32'h0,         32'h1000_0001, 32'hBFC0_0004, 1'b1, 32'h1000_0001);
        tbl[2]  = mk(6'b000000, 1'b0, 32'h0,         32'h1000_0002, 32'hBFC0_0008, 1'b1, 32'h1000_0002);
        tbl[3]  = mk(6'b000000, 1'b1, 32'hBFC0_0100, 32'h1000_0003, 32'hBFC0_0100, 1'b1, 32'h1000_0003);
        tbl[4]  = mk(6'b000000, 1'b0, 32'h0,         32'h2408_0001, 32'hBFC0_0104, 1'b1, 32'h2408_0001);
        tbl[5]  = mk(6'b000011, 1'b0, 32'h0,         32'h2408_0001, 32'hBFC0_0104, 1'b1, 32'h2408_0001);
        tbl[6]  = mk(6'b000011, 1'b0, 32'h0,         32'h2408_0001, 32'hBFC0_0104, 1'b1, 32'h2408_0001);
        tbl[7]  = mk(6'b000011, 1'b0, 32'h0,         32'h2409_0002, 32'hBFC0_0104, 1'b1, 32'h2408_0001);
        tbl[8]  = mk(6'b000000, 1'b0, 32'h0,         32'h2409_0002, 32'hBFC0_0108, 1'b1, 32'h2409_0002);
        tbl[9]  = mk(6'b000001, 1'b1, 32'hBFC0_0200, 32'h1000_0004, 32'hBFC0_0108, 1'b1, 32'h1000_0004);
        tbl[10] = mk(6'b000000, 1'b1, 32'hBFC0_0200, 32'h1000_0005, 32'hBFC0_0200, 1'b1, 32'h1000_0005);
        tbl[11] = mk(6'b000011, 1'b0, 32'h0,         32'h1000_0006, 32'hBFC0_0200, 1'b1, 32'h1000_0005);
        tbl[12] = mk(6'b000001, 1'b0, 32'h0,         32'h1000_0007, 32'hBFC0_0200, 1'b1, 32'h1000_0007);
        tbl[13] = mk(6'b000010, 1'b0, 32'h0,         32'h1000_0008, 32'hBFC0_0204, 1'b1, 32'h1000_0007);
        tbl[14] = mk(6'b000000, 1'b0, 32'h0,         32'h1000_0009, 32'hBFC0_0208, 1'b1, 32'h1000_0009);
        tbl[15] = mk(6'b000000, 1'b1, 32'hFFFF_FFFC, 32'h0000_000A, 32'hFFFF_FFFC, 1'b1, 32'h0000_000A);
        tbl[16] = mk(6'b000000, 1'b0, 32'h0,         32'h0000_000B, 32'h0000_0000, 1'b1, 32'h0000_000B);
        tbl[17] = mk(6'b000000, 1'b1, 32'hFFFF_0003, 32'h0000_000C, 32'hFFFF_0003, 1'b1, 32'h0000_000C);
        tbl[18] = mk(6'b000100, 1'b0, 32'h0,         32'h0000_000D, 32'hFFFF_0007, 1'b1, 32'h0000_000D);

        // Reset state, with and without clock edges.
        #3;
        chk_outputs("reset", 32'hBFBF_FFFC, 1'b0, 32'hDEAD_0000);
        chk("wen", {28'd0, inst_sram_wen}, 32'd0);
        chk("wdata", inst_sram_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk_outputs("reset_clocked", 32'hBFBF_FFFC, 1'b0, 32'hDEAD_0000);
        rst = 1'b0;
        #1 chk_outputs("post_release", 32'hBFBF_FFFC, 1'b0, 32'hDEAD_0000);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].st, tbl[i].be, tbl[i].ba, tbl[i].rd);
            chk_outputs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ce, tbl[i].inst);
        end

        // Async reset between edges while the hold buffer is full.
        drive(6'b000011, 1'b0, 32'h0, 32'hAAAA_0001);
        drive(6'b000011, 1'b1, 32'h1234_5678, 32'hAAAA_0002);
        chk_outputs("held", 32'hFFFF_0007, 1'b1, 32'h0000_000D);
        @(posedge clk);
        #3 inst_sram_rdata = 32'h5555_5555;
        #1 rst = 1'b1;
        #1 chk_outputs("async_rst", 32'hBFBF_FFFC, 1'b0, 32'h5555_5555);
        @(negedge clk);
        rst = 1'b0;
        stall = 6'b000000;
        #1 chk_outputs("rst_release", 32'hBFBF_FFFC, 1'b0, 32'h5555_5555);
        drive(6'b000000, 1'b0, 32'h0, 32'h6666_0000);
        chk_outputs("refetch", 32'hBFC0_0000, 1'b1, 32'h6666_0000);

        // Randomized run against the model: PC follows taken redirects or
        // steps by 4 when IF runs; ID sees the word present at stall onset.
        m_pc     = 32'hBFC0_0000;
        m_ce     = 1'b1;
        m_frozen = 1'b0;
        m_word   = 32'd0;
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  st;
            logic        be;
            logic [31:0] ba;
            logic [31:0] rd;
            st = 6'($urandom_range(0, 63));
            be = ($urandom_range(0, 3) == 0);
            ba = $urandom;
            rd = $urandom;
            if (!st[0]) begin
                m_pc = be ? ba : m_pc + 32'd4;
                m_ce = 1'b1;
            end
            if (st[1]) begin
                if (!m_frozen) m_word = inst_sram_rdata;
                m_frozen = 1'b1;
            end else begin
                m_frozen = 1'b0;
            end
            drive(st, be, ba, rd);
            chk("rnd pc", if_to_id_bus[31:0], m_pc);
            chk("rnd ce", {31'd0, inst_sram_en}, {31'd0, m_ce});
            chk("rnd inst", inst_out, m_frozen ? m_word : rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
